// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the minifloat MAC job sequencer.
// TPU_SEQ_ERR_ABORT_EN adds the DRAIN state used after an errored beat.
package tpu_seq_pkg;

  localparam int MF_W   = 8;
  localparam int ACC_W  = 34;
  localparam int HALF_W = 17;

  localparam logic [MF_W-1:0] ZERO_OP = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_READ_HI = 3'd2,
    S_READ_LO = 3'd3,
    S_DONE    = 3'd4
`ifdef TPU_SEQ_ERR_ABORT_EN
    ,
    S_DRAIN   = 3'd5
`endif
  } seq_state_e;

  // States in which operand beats are handshaken.
  function automatic logic takes_beats(
    input seq_state_e s
  );
`ifdef TPU_SEQ_ERR_ABORT_EN
    return (s == S_FEED) || (s == S_DRAIN);
`else
    return (s == S_FEED);
`endif
  endfunction

  // States that hold the MAC accumulator at zero.
  function automatic logic clears_mac(
    input seq_state_e s
  );
    return (s == S_IDLE) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/tpu_seq_len_counter.sv
// Beat down-counter for the MAC sequencer.
// Loads the job length, decrements per beat, flags the final beat.
module tpu_seq_len_counter #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [LEN_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == LEN_W'(1));

endmodule

// File: rtl/tpu_mac_sequencer.sv
// Job controller streaming operand pairs into the minifloat MAC.
// Optional TPU_SEQ_ERR_ABORT_EN: stop accumulating after first error.
module tpu_mac_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter logic [7:0]  ZERO_OP = tpu_seq_pkg::ZERO_OP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_start,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [33:0]      res_data,
  output logic             res_err,
  output logic             busy,
  output logic             mac_clear,
  output logic [7:0]       mac_in1,
  output logic [7:0]       mac_in2,
  output logic             mac_out_hl,
  input  logic [16:0]      mac_out,
  input  logic             mac_error
);

  import tpu_seq_pkg::*;

  seq_state_e       r_state;
  logic [ACC_W-1:0] r_res_data;
  logic             r_res_err;
  logic             r_res_valid;

  logic w_load;
  logic w_beat;
  logic w_feed_beat;
  logic w_last;
  logic w_len_zero;

  assign job_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign in_ready   = takes_beats(r_state);
  assign mac_clear  = clears_mac(r_state);
  assign mac_out_hl = (r_state == S_READ_HI);

  assign w_load      = job_ready & job_start;
  assign w_len_zero  = (job_len == '0);
  assign w_beat      = in_valid & in_ready;
  assign w_feed_beat = w_beat & (r_state == S_FEED);

  // Only FEED beats reach the MAC; everything else multiplies zeros.
  assign mac_in1 = w_feed_beat ? in_a : ZERO_OP;
  assign mac_in2 = w_feed_beat ? in_b : ZERO_OP;

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

  tpu_seq_len_counter #(
    .LEN_W(LEN_W)
  ) u_len_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(job_len),
    .i_dec     (w_beat),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (job_start) begin
            r_res_err <= 1'b0;
            r_state   <= w_len_zero ? S_READ_HI
                                    : S_FEED;
          end
        end
        S_FEED: begin
          if (w_beat) begin
            r_res_err <= r_res_err | mac_error;
            if (w_last) begin
              r_state <= S_READ_HI;
`ifdef TPU_SEQ_ERR_ABORT_EN
            end else if (mac_error) begin
              r_state <= S_DRAIN;
`endif
            end
          end
        end
`ifdef TPU_SEQ_ERR_ABORT_EN
        S_DRAIN: begin
          if (w_beat && w_last) begin
            r_state <= S_READ_HI;
          end
        end
`endif
        S_READ_HI: begin
          r_res_data[ACC_W-1:HALF_W] <= mac_out;
          r_state <= S_READ_LO;
        end
        S_READ_LO: begin
          r_res_data[HALF_W-1:0] <= mac_out;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mac_sequencer.sv
// Scoreboard bench for tpu_mac_sequencer with a behavioural MAC.
// Honours TPU_SEQ_ERR_ABORT_EN in its reference model.
module tb_tpu_mac_sequencer;

  typedef struct packed {
    logic [33:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        job_start = 1'b0;
  logic [7:0]  job_len = 8'd0;
  logic        job_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [33:0] res_data;
  logic        res_err;
  logic        busy;
  logic        mac_clear;
  logic [7:0]  mac_in1;
  logic [7:0]  mac_in2;
  logic        mac_out_hl;
  logic [16:0] mac_out;
  logic        mac_error;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       exp_q[$];
  logic [7:0] ja[$];
  logic [7:0] jb[$];

  always #5 clk = ~clk;

  tpu_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .job_start (job_start),
    .job_len   (job_len),
    .job_ready (job_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .mac_clear (mac_clear),
    .mac_in1   (mac_in1),
    .mac_in2   (mac_in2),
    .mac_out_hl(mac_out_hl),
    .mac_out   (mac_out),
    .mac_error (mac_error)
  );

  // Minifloat {s,e[3:0],m[2:0]}: e==0 is m, else 1.m scaled by 2^(e-1).
  function automatic longint mf_val(input logic [7:0] x);
    longint mag;
    if (x[6:3] == 4'd0)
      mag = longint'(x[2:0]);
    else
      mag = longint'({1'b1, x[2:0]}) << (int'(x[6:3]) - 1);
    return x[7] ? -mag : mag;
  endfunction

  function automatic logic mf_err(input logic [7:0] x);
    return x[6:3] == 4'hF;
  endfunction

  logic [33:0] m_acc = '0;

  always @(posedge clk) begin
    if (mac_clear)
      m_acc <= '0;
    else
      m_acc <= m_acc + 34'(mf_val(mac_in1) * mf_val(mac_in2));
  end

  assign mac_out   = mac_out_hl ? m_acc[33:17] : m_acc[16:0];
  assign mac_error = mf_err(mac_in1) | mf_err(mac_in2);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic exp_t ref_job(input int len);
    exp_t r;
    r.d = '0;
    r.e = 1'b0;
    for (int i = 0; i < len; i++) begin
      r.d = r.d + 34'(mf_val(ja[i]) * mf_val(jb[i]));
      if (mf_err(ja[i]) || mf_err(jb[i])) begin
        r.e = 1'b1;
`ifdef TPU_SEQ_ERR_ABORT_EN
        break;
`endif
      end
    end
    return r;
  endfunction

  // Monitor: compare held result against the queue head, pop on accept.
  always @(negedge clk) begin
    if (reset) begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(res_valid), 64'd0);
        end else begin
          chk("res_data", 64'(res_data), 64'(exp_q[0].d));
          chk("res_err", 64'(res_err), 64'(exp_q[0].e));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (!in_ready) begin
        chk("idle_op1", 64'(mac_in1), 64'd0);
        chk("idle_op2", 64'(mac_in2), 64'd0);
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!job_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("job_ready_wait", 64'(job_ready), 64'd1);
  endtask

  task automatic run_job(input int len, input int gap_max,
                         input int rdy_dly, input bit poke);
    int k;
    wait_ready();
    exp_q.push_back(ref_job(len));
    job_start = 1'b1;
    job_len   = 8'(len);
    @(posedge clk); #1;
    job_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        if (poke) begin
          job_start = 1'b1;
          job_len   = 8'd2;
        end
        @(posedge clk); #1;
        job_start = 1'b0;
      end
      in_valid = 1'b1;
      in_a = ja[i];
      in_b = jb[i];
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    k = 1;
    while (!res_valid && k < 20) begin
      if (len == 0) begin
        in_valid = 1'b1;
        in_a = 8'h01;
        in_b = 8'h01;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(k), 64'd3);
    repeat (rdy_dly) begin
      chk("valid_held", 64'(res_valid), 64'd1);
      if (poke) begin
        job_start = 1'b1;
        job_len   = 8'd1;
      end
      @(posedge clk); #1;
      job_start = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("job_ready_after", 64'(job_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("clear_idle", 64'(mac_clear), 64'd1);
  endtask

  task automatic chk_reset_state();
    chk("rst_job_ready", 64'(job_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mac_clear", 64'(mac_clear), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    #2 reset = 1'b0;
    #1 chk_reset_state();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    ja = '{8'h01, 8'h01, 8'h01};
    jb = '{8'h01, 8'h01, 8'h01};
    run_job(3, 0, 0, 1'b0);

    ja = '{8'h81};
    jb = '{8'h01};
    run_job(1, 0, 1, 1'b0);
    ja = '{8'h01};
    jb = '{8'h01};
    run_job(1, 0, 0, 1'b0);

    run_job(0, 0, 2, 1'b0);

    ja = '{8'h09, 8'h12, 8'h01, 8'h20};
    jb = '{8'h0A, 8'h83, 8'h05, 8'h11};
    run_job(4, 3, 5, 1'b1);

    // Reset in the middle of a job, after two beats.
    ja = '{8'h11, 8'h12, 8'h13, 8'h14};
    jb = '{8'h21, 8'h22, 8'h23, 8'h24};
    wait_ready();
    job_start = 1'b1;
    job_len   = 8'd4;
    @(posedge clk); #1;
    job_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = ja[i];
      in_b = jb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_state();
    @(posedge clk); #1;
    reset = 1'b1;
    ja = '{8'h01};
    jb = '{8'h01};
    run_job(1, 0, 0, 1'b0);

    ja = '{8'h01, 8'h7F, 8'h01};
    jb = '{8'h01, 8'h7F, 8'h01};
    run_job(3, 1, 1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      len = int'($urandom_range(0, 6));
      ja.delete();
      jb.delete();
      for (int i = 0; i < len; i++) begin
        ja.push_back(8'($urandom_range(0, 255)));
        jb.push_back(8'($urandom_range(0, 255)));
      end
      run_job(len, 2, int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
